isq_alloc: RTL and testbench
============================

ISQ_ALLOC -- requirements
Module: isq_alloc

Interface
REQ-001 Parameter ISQ_DEPTH, default 64, number of issue-queue lines.
REQ-002 Parameter ISQ_IDX_BITS_NUM, default 6, width of a line index.
REQ-003 Parameter INST_PORT, default 4, dispatch ports per cycle; ISQ_DEPTH SHALL be a multiple of INST_PORT.
REQ-004 One clock, clk; reset is asynchronous and active-high, rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 dsp_vld  input  INST_PORT  per-port dispatch valid.
REQ-008 iss_free  input  ISQ_DEPTH  per-line release pulse from issue/select.
REQ-009 fls  input  1  pipeline flush; all lines released.
REQ-010 isq_rdy  output  1  every lane has at least one free line.
REQ-011 isq_en  output  1  global write enable to the issue queue.
REQ-012 isq_lin_en  output  ISQ_DEPTH  per-line write enable.
REQ-013 alloc_idx_flat  output  INST_PORT*ISQ_IDX_BITS_NUM  allocated line index per port; port p in bits [6p+5:6p].
REQ-014 free_cnt  output  ISQ_IDX_BITS_NUM+1  registered count of free lines.

Function
REQ-015 Line i is fed only by port i mod INST_PORT; lane p owns lines {p, p+4, p+8, ...} (16 lines at defaults).
REQ-016 A free_vec register of ISQ_DEPTH bits SHALL hold 1 for each free line.
REQ-017 Lane p SHALL select the lowest-indexed free line it owns; alloc_idx for p is that index, 0 if none.
REQ-018 isq_rdy SHALL be combinational from free_vec and fls only: 1 when fls=0 and every lane owns at least one free line.
REQ-019 No combinational path from dsp_vld to isq_rdy.
REQ-020 Accept: acc = isq_rdy & (|dsp_vld); isq_en = acc.
REQ-021 isq_lin_en[i] = acc & dsp_vld[p] & (line i is lane p's pick); at most one bit per lane, zero when acc=0.
REQ-022 Zero-cycle latency: isq_lin_en and alloc_idx are valid in the same cycle as dsp_vld; the issue queue captures on that edge.
REQ-023 Next edge: free_vec clears every bit set in isq_lin_en and sets every bit set in iss_free.
REQ-024 A line released by iss_free becomes allocatable the cycle after the pulse, never in the same cycle.
REQ-025 iss_free on a line already free is a no-op; free_cnt does not overflow.
REQ-026 fls=1: isq_rdy=0 and isq_lin_en=0 that cycle; free_vec becomes all ones and free_cnt=ISQ_DEPTH next edge; fls overrides iss_free and allocation.
REQ-027 free_cnt = popcount(next free_vec), registered; range 0..ISQ_DEPTH.
REQ-028 A partial bundle (some dsp_vld bits 0) consumes lines only for valid ports.

Reset
REQ-029 rst=1 asynchronously sets free_vec all ones and free_cnt=ISQ_DEPTH; with fls=0, isq_rdy=1, isq_en=0, and isq_lin_en=0 while dsp_vld=0.
REQ-030 Reset asserted mid-operation discards all allocations immediately; the first post-reset allocation on lane p picks line p.

Structure
REQ-031 Shared package isq_pkg holds ISQ_DEPTH, ISQ_IDX_BITS_NUM, INST_PORT, and LANE_DEPTH = ISQ_DEPTH/INST_PORT; the issue queue and select logic use the same package.
REQ-032 One sub-module, isq_lane_pick: a LANE_DEPTH-input lowest-index priority encoder outputting found and index, instantiated INST_PORT times.
REQ-033 The only sequential state is free_vec and free_cnt.

Verification
REQ-034 After reset, dsp_vld=4'b1111 -> isq_lin_en bits {0,1,2,3}, alloc_idx {0,1,2,3}, free_cnt=60 next cycle.
REQ-035 Issue 16 full bundles -> isq_rdy=0 and free_cnt=0 afterward; further dsp_vld produces isq_lin_en=0.
REQ-036 From full, iss_free pulse on line 6 -> next cycle isq_rdy stays 0 (lanes 0,1,3 empty); dsp_vld=4'b0100 still not accepted.
REQ-037 Half-full queue, same cycle iss_free[0]=1 and dsp_vld=4'b0001 -> allocation avoids line 0; line 0 is picked the following cycle.
REQ-038 Random traffic, then fls=1 with dsp_vld=4'b1111 -> isq_lin_en=0 that cycle, free_cnt=64 next cycle.
REQ-039 rst asserted mid-stream between edges -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/isq_pkg.sv
// Issue-queue sizing shared by the allocator, the issue queue array and select logic.
// Lanes interleave lines so that lane p owns lines p, p+INST_PORT, p+2*INST_PORT, ...
package isq_pkg;
    localparam int ISQ_DEPTH        = 64;
    localparam int ISQ_IDX_BITS_NUM = 6;
    localparam int INST_PORT        = 4;
    localparam int LANE_DEPTH       = ISQ_DEPTH / INST_PORT;
    localparam int LANE_IDX_BITS    = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
endpackage

// File: rtl/isq_lane_pick.sv
// Lowest-index priority encoder over the free lines owned by one dispatch lane.
module isq_lane_pick #(
    parameter int LANE_DEPTH = isq_pkg::LANE_DEPTH,
    parameter int LANE_BITS  = isq_pkg::LANE_IDX_BITS
) (
    input  logic [LANE_DEPTH-1:0] free_bits,
    output logic                  found,
    output logic [LANE_BITS-1:0]  idx
);

    always_comb begin
        found = |free_bits;
        idx   = '0;
        // Scan downward so the last hit written is the lowest index.
        for (int i = LANE_DEPTH - 1; i >= 0; i--) begin
            if (free_bits[i]) begin
                idx = LANE_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/isq_alloc.sv
// Issue-queue line allocator: each dispatch lane takes the lowest free line it owns,
// zero-cycle latency; releases and flush land on the following edge.
module isq_alloc #(
    parameter int ISQ_DEPTH        = isq_pkg::ISQ_DEPTH,
    parameter int ISQ_IDX_BITS_NUM = isq_pkg::ISQ_IDX_BITS_NUM,
    parameter int INST_PORT        = isq_pkg::INST_PORT
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [INST_PORT-1:0]                  dsp_vld,
    input  logic [ISQ_DEPTH-1:0]                  iss_free,
    input  logic                                  fls,
    output logic                                  isq_rdy,
    output logic                                  isq_en,
    output logic [ISQ_DEPTH-1:0]                  isq_lin_en,
    output logic [INST_PORT*ISQ_IDX_BITS_NUM-1:0] alloc_idx_flat,
    output logic [ISQ_IDX_BITS_NUM:0]             free_cnt
);

    localparam int LANE_DEPTH = ISQ_DEPTH / INST_PORT;
    localparam int LANE_BITS  = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
    localparam int IW         = ISQ_IDX_BITS_NUM;
    localparam int CW         = ISQ_IDX_BITS_NUM + 1;

    logic [ISQ_DEPTH-1:0]                 free_vec_reg;
    logic [ISQ_DEPTH-1:0]                 free_vec_next;
    logic [CW-1:0]                        free_cnt_reg;
    logic [CW-1:0]                        free_cnt_next;
    logic [INST_PORT-1:0]                 lane_found;
    logic [INST_PORT-1:0][LANE_BITS-1:0]  lane_idx;
    logic                                 acc;

    genvar gi, gj;
    generate
        for (gi = 0; gi < INST_PORT; gi++) begin : g_lane
            logic [LANE_DEPTH-1:0] lane_free;

            for (gj = 0; gj < LANE_DEPTH; gj++) begin : g_gather
                assign lane_free[gj] = free_vec_reg[gj*INST_PORT + gi];
            end

            isq_lane_pick #(
                .LANE_DEPTH (LANE_DEPTH),
                .LANE_BITS  (LANE_BITS)
            ) u_pick (
                .free_bits (lane_free),
                .found     (lane_found[gi]),
                .idx       (lane_idx[gi])
            );

            assign alloc_idx_flat[gi*IW +: IW] = lane_found[gi]
                ? (IW'(lane_idx[gi]) * IW'(INST_PORT) + IW'(gi))
                : '0;
        end
    endgenerate

    // Ready depends only on registered state and flush, never on dsp_vld.
    assign isq_rdy = ~fls & (&lane_found);
    assign acc     = isq_rdy & (|dsp_vld);
    assign isq_en  = acc;

    generate
        for (gi = 0; gi < ISQ_DEPTH; gi++) begin : g_line
            localparam int LANE = gi % INST_PORT;
            localparam int SLOT = gi / INST_PORT;
            assign isq_lin_en[gi] = acc & dsp_vld[LANE] & lane_found[LANE]
                                  & (lane_idx[LANE] == LANE_BITS'(SLOT));
        end
    endgenerate

    // A line allocated this cycle stays taken even if a stray release targets it.
    always_comb begin
        free_vec_next = fls ? '1 : ((free_vec_reg | iss_free) & ~isq_lin_en);
        free_cnt_next = '0;
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            free_cnt_next = free_cnt_next + CW'(free_vec_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_vec_reg <= '1;
            free_cnt_reg <= CW'(ISQ_DEPTH);
        end else begin
            free_vec_reg <= free_vec_next;
            free_cnt_reg <= free_cnt_next;
        end
    end

    assign free_cnt = free_cnt_reg;

endmodule

// File: tb/tb_isq_alloc.sv
// Scenario bench for isq_alloc: a line-level reference model predicts each cycle's
// outputs, which a negedge scoreboard compares against the DUT.
module tb_isq_alloc;

    localparam int D = 64;
    localparam int P = 4;
    localparam int W = 6;

    typedef struct packed {
        logic         rdy;
        logic         en;
        logic [D-1:0] lin;
        logic [P*W-1:0] idx;
        logic [W:0]   cnt;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [P-1:0]   dsp_vld = '0;
    logic [D-1:0]   iss_free = '0;
    logic           fls = 1'b0;
    logic           isq_rdy;
    logic           isq_en;
    logic [D-1:0]   isq_lin_en;
    logic [P*W-1:0] alloc_idx_flat;
    logic [W:0]     free_cnt;

    int errors = 0;
    int checks = 0;

    logic [D-1:0] model_free = '1;
    exp_t         sb[$];
    logic [D-1:0] cur_lin, cur_f;
    logic         cur_fl;

    isq_alloc dut (
        .clk            (clk),
        .rst            (rst),
        .dsp_vld        (dsp_vld),
        .iss_free       (iss_free),
        .fls            (fls),
        .isq_rdy        (isq_rdy),
        .isq_en         (isq_en),
        .isq_lin_en     (isq_lin_en),
        .alloc_idx_flat (alloc_idx_flat),
        .free_cnt       (free_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_expect(input logic [P-1:0] v, input logic fl);
        exp_t e;
        logic [P-1:0] found;
        int pick [P];
        e = '0;
        found = '0;
        for (int p = 0; p < P; p++) begin
            pick[p] = 0;
            for (int k = D/P - 1; k >= 0; k--) begin
                if (model_free[k*P + p]) begin
                    found[p] = 1'b1;
                    pick[p]  = k*P + p;
                end
            end
            e.idx[p*W +: W] = found[p] ? W'(pick[p]) : '0;
        end
        e.rdy = !fl && (&found);
        e.en  = e.rdy && (|v);
        for (int p = 0; p < P; p++) begin
            if (e.en && v[p]) e.lin[pick[p]] = 1'b1;
        end
        e.cnt = (W+1)'($countones(model_free));
        return e;
    endfunction

    // Called at posedge+1: apply inputs and queue the expected response.
    task automatic drive(input logic [P-1:0] v, input logic [D-1:0] f, input logic fl);
        exp_t e;
        dsp_vld  = v;
        iss_free = f;
        fls      = fl;
        e = model_expect(v, fl);
        cur_lin = e.lin;
        cur_f   = f;
        cur_fl  = fl;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        if (cur_fl) model_free = '1;
        else        model_free = (model_free | cur_f) & ~cur_lin;
        #1;
    endtask

    task automatic cycle(input logic [P-1:0] v, input logic [D-1:0] f, input logic fl);
        drive(v, f, fl);
        tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks += 4;
            if (isq_rdy !== e.rdy) begin
                errors++;
                $display("FAIL sb_rdy: got %0b want %0b", isq_rdy, e.rdy);
            end
            if (isq_en !== e.en) begin
                errors++;
                $display("FAIL sb_en: got %0b want %0b", isq_en, e.en);
            end
            if (isq_lin_en !== e.lin) begin
                errors++;
                $display("FAIL sb_lin_en: got %h want %h", isq_lin_en, e.lin);
            end
            if (free_cnt !== e.cnt) begin
                errors++;
                $display("FAIL sb_free_cnt: got %0d want %0d", free_cnt, e.cnt);
            end
            if (e.en) begin
                checks++;
                if (alloc_idx_flat !== e.idx) begin
                    errors++;
                    $display("FAIL sb_alloc_idx: got %h want %h", alloc_idx_flat, e.idx);
                end
            end
            $display("txn vld=%b rdy=%0b en=%0b lin=%h idx=%h cnt=%0d",
                     dsp_vld, isq_rdy, isq_en, isq_lin_en, alloc_idx_flat, free_cnt);
        end
    end

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks += 4;
        if (free_cnt !== 7'd64) begin errors++; $display("FAIL reset_cnt: got %0d want 64", free_cnt); end
        if (isq_rdy !== 1'b1)   begin errors++; $display("FAIL reset_rdy: got %0b want 1", isq_rdy); end
        if (isq_en !== 1'b0)    begin errors++; $display("FAIL reset_en: got %0b want 0", isq_en); end
        if (isq_lin_en !== '0)  begin errors++; $display("FAIL reset_lin: got %h want 0", isq_lin_en); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_free = '1;
    endtask

    task automatic test_first_bundle();
        drive(4'b1111, '0, 1'b0);
        #1;
        checks += 2;
        if (isq_lin_en !== 64'hF) begin errors++; $display("FAIL first_lin: got %h want f", isq_lin_en); end
        if (alloc_idx_flat !== {6'd3, 6'd2, 6'd1, 6'd0}) begin
            errors++; $display("FAIL first_idx: got %h want %h", alloc_idx_flat, {6'd3, 6'd2, 6'd1, 6'd0});
        end
        tick();
        checks++;
        if (free_cnt !== 7'd60) begin errors++; $display("FAIL first_cnt: got %0d want 60", free_cnt); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 15; i++) cycle(4'b1111, '0, 1'b0);
        checks += 2;
        if (isq_rdy !== 1'b0)  begin errors++; $display("FAIL fill_rdy: got %0b want 0", isq_rdy); end
        if (free_cnt !== 7'd0) begin errors++; $display("FAIL fill_cnt: got %0d want 0", free_cnt); end
        cycle(4'b1111, '0, 1'b0);
    endtask

    task automatic test_release_one_lane();
        cycle(4'b0000, 64'h1 << 6, 1'b0);
        checks += 2;
        if (isq_rdy !== 1'b0)  begin errors++; $display("FAIL rel_rdy: got %0b want 0", isq_rdy); end
        if (free_cnt !== 7'd1) begin errors++; $display("FAIL rel_cnt: got %0d want 1", free_cnt); end
        drive(4'b0100, '0, 1'b0);
        #1;
        checks++;
        if (isq_lin_en !== '0) begin errors++; $display("FAIL rel_lin: got %h want 0", isq_lin_en); end
        tick();
    endtask

    task automatic test_free_same_cycle();
        cycle(4'b0000, '0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(4'b1111, '0, 1'b0);
        drive(4'b0001, 64'h1, 1'b0);
        #1;
        checks++;
        if (alloc_idx_flat[W-1:0] !== 6'd32) begin
            errors++; $display("FAIL same_cycle_idx: got %0d want 32", alloc_idx_flat[W-1:0]);
        end
        tick();
        drive(4'b0001, '0, 1'b0);
        #1;
        checks++;
        if (isq_lin_en !== 64'h1) begin errors++; $display("FAIL next_cycle_lin: got %h want 1", isq_lin_en); end
        tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 40; i++) begin
            logic [D-1:0] f;
            f = '0;
            if ($urandom_range(1) == 1) f[$urandom_range(D-1)] = 1'b1;
            cycle(4'($urandom_range(15)), f, 1'b0);
        end
        drive(4'b1111, '0, 1'b1);
        #1;
        checks += 2;
        if (isq_lin_en !== '0) begin errors++; $display("FAIL fls_lin: got %h want 0", isq_lin_en); end
        if (isq_rdy !== 1'b0)  begin errors++; $display("FAIL fls_rdy: got %0b want 0", isq_rdy); end
        tick();
        checks++;
        if (free_cnt !== 7'd64) begin errors++; $display("FAIL fls_cnt: got %0d want 64", free_cnt); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cycle(4'b1011, '0, 1'b0);
        dsp_vld  = '0;
        iss_free = '0;
        #1 rst = 1'b1;
        #1;
        checks += 3;
        if (free_cnt !== 7'd64) begin errors++; $display("FAIL arst_cnt: got %0d want 64", free_cnt); end
        if (isq_rdy !== 1'b1)   begin errors++; $display("FAIL arst_rdy: got %0b want 1", isq_rdy); end
        if (isq_lin_en !== '0)  begin errors++; $display("FAIL arst_lin: got %h want 0", isq_lin_en); end
        model_free = '1;
        @(posedge clk);
        #1 rst = 1'b0;
        drive(4'b1111, '0, 1'b0);
        #1;
        checks++;
        if (alloc_idx_flat !== {6'd3, 6'd2, 6'd1, 6'd0}) begin
            errors++; $display("FAIL arst_idx: got %h want %h", alloc_idx_flat, {6'd3, 6'd2, 6'd1, 6'd0});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_first_bundle();
        test_fill();
        test_release_one_lane();
        test_free_same_cycle();
        test_flush();
        test_async_reset();
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
